// File: rtl/shape_pkg.sv
// shape_pkg: shared state and move-type encodings for the move scheduler
package shape_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCK} sched_state_e;
    typedef enum logic [1:0] {MV_NONE, MV_DOWN, MV_LEFT, MV_RIGHT} move_e;
endpackage

// File: rtl/move_req_latch.sv
// move_req_latch: turns a request pulse into a sticky pending flag
module move_req_latch (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic pend
);
    // A fresh request wins over a same-cycle clear so it is never lost
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pend <= 1'b0;
        else pend <= set | (pend & ~clr);
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: serialises player/gravity moves into one strobe at a time and requests a lock on a refused drop
module move_scheduler import shape_pkg::*; #(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  game_active,
    input  logic                  req_left,
    input  logic                  req_right,
    input  logic                  req_soft,
    input  logic                  gravity_tick,
    input  logic                  move_ok,
    input  logic                  lock_ack,
    output logic                  move_left,
    output logic                  move_right,
    output logic                  move_down,
    output logic                  lock_req,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_rows
);
    sched_state_e state, nxt;
    move_e grant, pick;
    logic grant_soft, start, flush;
    logic pend_l, pend_r, pend_soft, pend_grav;

    move_req_latch u_grav  (.clk(clk), .reset_n(reset_n), .set(gravity_tick & game_active),
                            .clr(flush | (start & pick == MV_DOWN)), .pend(pend_grav));
    move_req_latch u_soft  (.clk(clk), .reset_n(reset_n), .set(req_soft & game_active),
                            .clr(flush | (start & pick == MV_DOWN)), .pend(pend_soft));
    move_req_latch u_left  (.clk(clk), .reset_n(reset_n), .set(req_left & game_active),
                            .clr(flush | (start & pick == MV_LEFT)), .pend(pend_l));
    move_req_latch u_right (.clk(clk), .reset_n(reset_n), .set(req_right & game_active),
                            .clr(flush | (start & pick == MV_RIGHT)), .pend(pend_r));

    // Fixed-priority grant (down > left > right) and next-state selection
    always_comb begin
        pick  = (pend_grav | pend_soft) ? MV_DOWN : pend_l ? MV_LEFT : pend_r ? MV_RIGHT : MV_NONE;
        nxt   = !game_active ? IDLE :
                state == IDLE  ? (pick != MV_NONE ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? ((grant == MV_DOWN && !move_ok) ? LOCK : IDLE) :
                (lock_ack ? IDLE : LOCK);
        start = state == IDLE && nxt == ISSUE;
        flush = !game_active || (state == LOCK && lock_ack);
    end

    // FSM and registered strobes; a strobe is only ever raised on entry to ISSUE
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= MV_NONE;
            grant_soft <= 1'b0;
            move_down  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            lock_req   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt;
            grant      <= start ? pick : grant;
            grant_soft <= start ? pend_soft : grant_soft;
            move_down  <= start && pick == MV_DOWN;
            move_left  <= start && pick == MV_LEFT;
            move_right <= start && pick == MV_RIGHT;
            lock_req   <= nxt == LOCK;
            busy       <= nxt != IDLE;
        end

    // Saturating count of soft-drop rows that the datapath accepted
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) drop_rows <= '0;
        else if (game_active && state == WAIT && grant == MV_DOWN && grant_soft && move_ok && drop_rows != '1)
            drop_rows <= drop_rows + DROP_CNT_W'(1);
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed and random checks of move_scheduler against a transaction-level model
module tb_move_scheduler;
    logic clk = 0, reset_n = 1, game_active = 0;
    logic req_left = 0, req_right = 0, req_soft = 0, gravity_tick = 0, move_ok = 0, lock_ack = 0;
    logic move_left, move_right, move_down, lock_req, busy;
    logic move_left2, move_right2, move_down2, lock_req2, busy2;
    logic [7:0] drop_rows;
    logic [1:0] drop_rows2;
    int checks = 0, errors = 0;

    bit mp[4];
    int mmv = 0, mt = 0, mcnt = 0;
    bit mlock = 0, msoft = 0;

    move_scheduler #(.DROP_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .game_active(game_active), .req_left(req_left),
        .req_right(req_right), .req_soft(req_soft), .gravity_tick(gravity_tick),
        .move_ok(move_ok), .lock_ack(lock_ack), .move_left(move_left), .move_right(move_right),
        .move_down(move_down), .lock_req(lock_req), .busy(busy), .drop_rows(drop_rows));

    move_scheduler #(.DROP_CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .game_active(game_active), .req_left(req_left),
        .req_right(req_right), .req_soft(req_soft), .gravity_tick(gravity_tick),
        .move_ok(move_ok), .lock_ack(lock_ack), .move_left(move_left2), .move_right(move_right2),
        .move_down(move_down2), .lock_req(lock_req2), .busy(busy2), .drop_rows(drop_rows2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: pending set, current move with its age in cycles, lock flag, soft-drop tally
    task automatic model(input bit l, input bit r, input bit s, input bit g, input bit ok, input bit ack);
        if (!game_active) begin
            mp = '{default: 0};
            mmv = 0;
            mlock = 0;
        end else begin
            if (mlock) begin
                if (ack) begin
                    mlock = 0;
                    mp = '{default: 0};
                end
            end else if (mmv != 0) begin
                mt++;
                if (mt == 2) begin
                    if (mmv == 1 && !ok) mlock = 1;
                    else if (mmv == 1 && ok && msoft) mcnt++;
                    mmv = 0;
                end
            end else if (mp[0] | mp[1] | mp[2] | mp[3]) begin
                msoft = mp[1];
                mt = 0;
                if (mp[0] | mp[1]) begin
                    mmv = 1;
                    mp[0] = 0;
                    mp[1] = 0;
                end else if (mp[2]) begin
                    mmv = 2;
                    mp[2] = 0;
                end else begin
                    mmv = 3;
                    mp[3] = 0;
                end
            end
            if (g) mp[0] = 1;
            if (s) mp[1] = 1;
            if (l) mp[2] = 1;
            if (r) mp[3] = 1;
        end
    endtask

    task automatic check_all();
        chk("move_down", 32'(move_down), 32'(mmv == 1 && mt == 0));
        chk("move_left", 32'(move_left), 32'(mmv == 2 && mt == 0));
        chk("move_right", 32'(move_right), 32'(mmv == 3 && mt == 0));
        chk("lock_req", 32'(lock_req), 32'(mlock));
        chk("busy", 32'(busy), 32'(mmv != 0 || mlock));
        chk("drop_rows", 32'(drop_rows), 32'(mcnt > 255 ? 255 : mcnt));
        chk("drop_rows_w2", 32'(drop_rows2), 32'(mcnt > 3 ? 3 : mcnt));
        chk("w2_strobes", 32'({move_down2, move_left2, move_right2, lock_req2, busy2}),
            32'({move_down, move_left, move_right, lock_req, busy}));
    endtask

    task automatic step(input bit l, input bit r, input bit s, input bit g, input bit ok, input bit ack);
        req_left = l; req_right = r; req_soft = s; gravity_tick = g; move_ok = ok; lock_ack = ack;
        @(posedge clk);
        model(l, r, s, g, ok, ack);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit ok);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, ok, 0);
    endtask

    task automatic do_reset();
        #1 reset_n = 0;
        #1;
        mp = '{default: 0};
        mmv = 0; mlock = 0; mcnt = 0;
        chk("rst_outputs", 32'({move_down, move_left, move_right, lock_req, busy}), 0);
        chk("rst_drop", 32'(drop_rows), 0);
        @(posedge clk);
        #1 reset_n = 1;
    endtask

    initial begin
        game_active = 1;
        do_reset();
        // single left request: strobe two cycles later, back to idle at cycle 4
        step(1, 0, 0, 0, 0, 0);
        chk("left_c1", 32'(move_left), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("left_c2", 32'(move_left), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("left_c3", 32'(move_left), 0);
        step(0, 0, 0, 0, 1, 0);
        chk("left_busy_c4", 32'(busy), 0);
        // simultaneous left/right/gravity: down, left, right, 3 cycles apart
        step(1, 1, 0, 1, 1, 0);
        idle(1, 1);
        chk("prio_down", 32'(move_down), 1);
        idle(3, 1);
        chk("prio_left", 32'(move_left), 1);
        idle(3, 1);
        chk("prio_right", 32'(move_right), 1);
        idle(3, 1);
        // soft drops: count, then saturate the narrow counter
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 1, 0);
            idle(3, 1);
        end
        chk("soft3", 32'(drop_rows), 3);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0, 1, 0);
            idle(3, 1);
        end
        chk("soft5", 32'(drop_rows), 5);
        chk("soft5_sat", 32'(drop_rows2), 3);
        // refused gravity drop: lock held until ack, requests meanwhile flushed
        step(0, 0, 0, 1, 0, 0);
        idle(3, 0);
        for (int i = 0; i < 10; i++) begin
            step(i == 4, 0, 0, 0, 0, 0);
            chk("lock_held", 32'(lock_req), 1);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("lock_released", 32'(lock_req), 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("no_left_after_lock", 32'(move_left), 0);
        end
        // async reset in the middle of a WAIT
        step(0, 0, 1, 0, 1, 0);
        idle(2, 1);
        do_reset();
        // game_active dropped during LOCK
        step(0, 0, 0, 1, 0, 0);
        idle(3, 0);
        step(0, 1, 0, 0, 0, 0);
        game_active = 0;
        step(0, 0, 0, 0, 0, 0);
        chk("inactive_lock", 32'(lock_req), 0);
        game_active = 1;
        idle(4, 1);
        chk("reenable_idle", 32'(busy), 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            game_active = ($urandom_range(0, 39) != 0);
            step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
